// File: rtl/reg_rename_file_pkg.sv
// Shared configuration for the rename register file.
// Define REGFILE_COMMIT_BYPASS_EN to let reads see the committing value in the same cycle.
package reg_rename_file_pkg;

   localparam int ROB_SIZE_WIDTH = 4;
   localparam int CFG_XLEN       = 32;
   localparam int ROB_ID_NONE    = 0;

`ifdef REGFILE_COMMIT_BYPASS_EN
   localparam bit COMMIT_BYPASS = 1'b1;
`else
   localparam bit COMMIT_BYPASS = 1'b0;
`endif

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One combinational operand-resolution channel: forward, RoB answer, commit bypass or regfile.
// Commit bypass paths are active only when REGFILE_COMMIT_BYPASS_EN is defined.
module reg_read_port
   import reg_rename_file_pkg::*;
#(
   parameter int XW = 32,
   parameter int RW = 5,
   parameter int TW = 4
) (
   input  logic [RW-1:0] rs,
   input  logic [XW-1:0] reg_value,
   input  logic          reg_has_dep,
   input  logic [TW-1:0] reg_tag,
   input  logic          issue_valid,
   input  logic [RW-1:0] issue_rd,
   input  logic [TW-1:0] issue_rob_id,
   input  logic          commit_live,
   input  logic [RW-1:0] commit_rd,
   input  logic [TW-1:0] commit_rob_id,
   input  logic [XW-1:0] commit_value,
   input  logic [XW-1:0] rob_value,
   input  logic          rob_ready,
   output logic [XW-1:0] value,
   output logic          has_dep,
   output logic [TW-1:0] dep_rob_id,
   output logic [TW-1:0] ask_rob_id
);

   logic          fwd, pend, byp_pend, byp_reg;
   logic [TW-1:0] tag;

   always_comb begin
      fwd      = issue_valid && (issue_rd == rs) && (rs != '0);
      pend     = fwd || reg_has_dep;
      tag      = fwd ? issue_rob_id : reg_tag;
      // same-cycle issue forwarding outranks the commit bypass
      byp_pend = COMMIT_BYPASS && commit_live && pend && !fwd && (tag == commit_rob_id);
      byp_reg  = COMMIT_BYPASS && commit_live && !pend && (commit_rd == rs) && (rs != '0);
      ask_rob_id = pend ? tag : TW'(ROB_ID_NONE);
      value      = '0;
      has_dep    = 1'b0;
      dep_rob_id = TW'(ROB_ID_NONE);
      if (byp_pend)              value = commit_value;
      else if (pend && rob_ready) value = rob_value;
      else if (pend) begin
         has_dep    = 1'b1;
         dep_rob_id = tag;
      end
      else if (byp_reg)          value = commit_value;
      else                       value = reg_value;
   end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags and a live-tag counter.
// Build option REGFILE_COMMIT_BYPASS_EN adds same-cycle commit visibility on the read ports.
module reg_rename_file
   import reg_rename_file_pkg::*;
#(
   parameter int XLEN     = CFG_XLEN,
   parameter int NUM_REGS = 32,
   parameter int ROB_ID_W = ROB_SIZE_WIDTH,
   parameter int NUM_READ = 2,
   localparam int RW = $clog2(NUM_REGS),
   localparam int CW = $clog2(NUM_REGS + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rdy,
   input  logic                         flush,
   input  logic [ROB_ID_W-1:0]          issue_rob_id,
   input  logic [RW-1:0]                issue_rd,
   input  logic [ROB_ID_W-1:0]          commit_rob_id,
   input  logic [RW-1:0]                commit_rd,
   input  logic [XLEN-1:0]              commit_value,
   input  logic [NUM_READ*RW-1:0]       rd_idx,
   output logic [NUM_READ*XLEN-1:0]     rd_value,
   output logic [NUM_READ-1:0]          rd_has_dep,
   output logic [NUM_READ*ROB_ID_W-1:0] rd_dep_rob_id,
   output logic [NUM_READ*ROB_ID_W-1:0] ask_rob_id,
   input  logic [NUM_READ*XLEN-1:0]     rob_value,
   input  logic [NUM_READ-1:0]          rob_ready,
   output logic [CW-1:0]                busy_count
);

   logic [NUM_REGS-1:0][XLEN-1:0]     regs;
   logic [NUM_REGS-1:0]               has_dep;
   logic [NUM_REGS-1:0][ROB_ID_W-1:0] dep_tag;

   logic          issue_valid, commit_live, commit_valid, commit_clear, inc, dec;
   logic [CW-1:0] busy_nxt;

   always_comb begin
      issue_valid  = rdy && !flush && (issue_rob_id != ROB_ID_W'(ROB_ID_NONE)) && (issue_rd != '0);
      commit_live  = rdy && (commit_rob_id != ROB_ID_W'(ROB_ID_NONE));
      commit_valid = commit_live && (commit_rd != '0);
      commit_clear = commit_valid && has_dep[commit_rd] && (dep_tag[commit_rd] == commit_rob_id);
      inc = issue_valid && !has_dep[issue_rd];
      // a clear immediately re-tagged by the same-cycle issue leaves the count unchanged
      dec = commit_clear && !(issue_valid && (issue_rd == commit_rd));
      busy_nxt = busy_count;
      if (inc && !dec)      busy_nxt = busy_count + 1'b1;
      else if (dec && !inc) busy_nxt = busy_count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs       <= '0;
         has_dep    <= '0;
         dep_tag    <= '0;
         busy_count <= '0;
      end else if (rdy) begin
         if (commit_valid) regs[commit_rd] <= commit_value;
         if (flush) begin
            has_dep    <= '0;
            dep_tag    <= '0;
            busy_count <= '0;
         end else begin
            if (commit_clear) begin
               has_dep[commit_rd] <= 1'b0;
               dep_tag[commit_rd] <= ROB_ID_W'(ROB_ID_NONE);
            end
            if (issue_valid) begin
               has_dep[issue_rd] <= 1'b1;
               dep_tag[issue_rd] <= issue_rob_id;
            end
            busy_count <= busy_nxt;
         end
      end
   end

   for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
      logic [RW-1:0] rs;
      assign rs = rd_idx[k*RW +: RW];

      reg_read_port #(.XW(XLEN), .RW(RW), .TW(ROB_ID_W)) u_port (
         .rs            (rs),
         .reg_value     (regs[rs]),
         .reg_has_dep   (has_dep[rs]),
         .reg_tag       (dep_tag[rs]),
         .issue_valid   (issue_valid),
         .issue_rd      (issue_rd),
         .issue_rob_id  (issue_rob_id),
         .commit_live   (commit_live),
         .commit_rd     (commit_rd),
         .commit_rob_id (commit_rob_id),
         .commit_value  (commit_value),
         .rob_value     (rob_value[k*XLEN +: XLEN]),
         .rob_ready     (rob_ready[k]),
         .value         (rd_value[k*XLEN +: XLEN]),
         .has_dep       (rd_has_dep[k]),
         .dep_rob_id    (rd_dep_rob_id[k*ROB_ID_W +: ROB_ID_W]),
         .ask_rob_id    (ask_rob_id[k*ROB_ID_W +: ROB_ID_W])
      );
   end

endmodule
